// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
    parameter int ADDR_W = 10
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ack bus, sizes load/store
// data, resolves branches, registers the write-back bundle and stalls upstream while busy.
module mem_access_stage #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] result_in,
    input  logic [31:0] registro_2_in,
    input  logic [10:0] jump_dest_addr_in,
    input  logic        zero_signal_in,
    input  logic [4:0]  reg_dest_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic [2:0]  trunk_mode_in,
    mem_access_stage_if.master mem_bus,
    output logic        stall_out,
    output logic        pc_src_out,
    output logic [10:0] branch_addr_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_reg_dest_out,
    output logic        wb_RegWrite_out,
    output logic        mem_err_out
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [3:0]        r_mem_be, w_mem_be_nxt;
    logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
    logic [31:0]       r_wb_data, w_wb_data_nxt;
    logic [4:0]        r_wb_dest, w_wb_dest_nxt;
    logic              r_wb_we, w_wb_we_nxt;
    logic              r_err, w_err_nxt;

    logic        w_op;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_sign;
    logic        w_misaligned;
    logic        w_cnt_last;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_ld_data;

    assign w_op       = MemRead_in | MemWrite_in;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Size/sign decode of trunk_mode; unused encodings fall back to word.
    always_comb begin
        w_is_half = 1'b0;
        w_is_byte = 1'b0;
        w_sign    = 1'b0;
        case (trunk_mode_in)
            3'b001:  w_is_half = 1'b1;
            3'b010:  begin w_is_half = 1'b1; w_sign = 1'b1; end
            3'b011:  w_is_byte = 1'b1;
            3'b100:  begin w_is_byte = 1'b1; w_sign = 1'b1; end
            default: w_is_half = 1'b0;
        endcase
    end

    assign w_misaligned = (~w_is_half & ~w_is_byte & (result_in[1:0] != 2'b00)) |
                          (w_is_half & result_in[0]);

    // Little-endian lane placement of store data; reads always enable all four lanes.
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = registro_2_in;
        if (w_is_byte) begin
            w_st_be    = 4'b0001 << result_in[1:0];
            w_st_wdata = {4{registro_2_in[7:0]}};
        end else if (w_is_half) begin
            w_st_be    = result_in[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{registro_2_in[15:0]}};
        end else begin
            w_st_be    = 4'b1111;
            w_st_wdata = registro_2_in;
        end
        if (MemRead_in) begin
            w_st_be = 4'b1111;
        end else begin
            w_st_be = w_st_be;
        end
    end

    // Load lane extraction followed by zero/sign extension.
    always_comb begin
        case (result_in[1:0])
            2'b00:   w_rd_byte = mem_bus.mem_rdata[7:0];
            2'b01:   w_rd_byte = mem_bus.mem_rdata[15:8];
            2'b10:   w_rd_byte = mem_bus.mem_rdata[23:16];
            2'b11:   w_rd_byte = mem_bus.mem_rdata[31:24];
            default: w_rd_byte = 8'h00;
        endcase
        w_rd_half = result_in[1] ? mem_bus.mem_rdata[31:16] : mem_bus.mem_rdata[15:0];
        if (w_is_byte) begin
            w_ld_data = {{24{w_sign & w_rd_byte[7]}}, w_rd_byte};
        end else if (w_is_half) begin
            w_ld_data = {{16{w_sign & w_rd_half[15]}}, w_rd_half};
        end else begin
            w_ld_data = mem_bus.mem_rdata;
        end
    end

    // Next-state and next-register computation for the IDLE/WAIT access FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_wb_data_nxt   = r_wb_data;
        w_wb_dest_nxt   = r_wb_dest;
        w_wb_we_nxt     = r_wb_we;
        w_err_nxt       = r_err;
        case (r_state)
            ST_IDLE: begin
                if (!w_op) begin
                    w_wb_data_nxt = result_in;
                    w_wb_dest_nxt = reg_dest_in;
                    w_wb_we_nxt   = RegWrite_in;
                end else if (w_misaligned) begin
                    w_wb_we_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = MemWrite_in & ~MemRead_in;
                    w_mem_addr_nxt  = result_in[ADDR_W+1:2];
                    w_mem_be_nxt    = w_st_be;
                    w_mem_wdata_nxt = w_st_wdata;
                    w_wb_we_nxt     = 1'b0;
                    w_cnt_nxt       = {CNT_W{1'b0}};
                    w_state_nxt     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ack takes priority over an expiring timeout on the same edge.
                if (mem_bus.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                    w_wb_data_nxt = (MemRead_in & MemToReg_in) ? w_ld_data : result_in;
                    w_wb_dest_nxt = reg_dest_in;
                    w_wb_we_nxt   = RegWrite_in;
                end else if (w_cnt_last) begin
                    w_mem_req_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_wb_we_nxt   = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_mem_req_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // Stage registers; the pipeline updates on the falling clock edge.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_wb_data   <= 32'h0000_0000;
            r_wb_dest   <= 5'd0;
            r_wb_we     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_wb_dest   <= w_wb_dest_nxt;
            r_wb_we     <= w_wb_we_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Stall drops on the ack cycle so upstream advances on the completing edge.
    assign stall_out = ((r_state == ST_IDLE) & w_op & ~w_misaligned) |
                       ((r_state == ST_WAIT) & ~mem_bus.mem_ack & ~w_cnt_last);

    assign pc_src_out      = Branch_in & zero_signal_in & ~stall_out;
    assign branch_addr_out = jump_dest_addr_in;

    assign mem_bus.mem_req   = r_mem_req;
    assign mem_bus.mem_we    = r_mem_we;
    assign mem_bus.mem_addr  = r_mem_addr;
    assign mem_bus.mem_be    = r_mem_be;
    assign mem_bus.mem_wdata = r_mem_wdata;

    assign wb_data_out     = r_wb_data;
    assign wb_reg_dest_out = r_wb_dest;
    assign wb_RegWrite_out = r_wb_we;
    assign mem_err_out     = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, sized loads/stores, misalignment,
// timeout, branch resolution and asynchronous reset during an outstanding access.
module tb_mem_access_stage;

    logic        clock;
    logic        reset_n;
    logic [31:0] result_in;
    logic [31:0] registro_2_in;
    logic [10:0] jump_dest_addr_in;
    logic        zero_signal_in;
    logic [4:0]  reg_dest_in;
    logic        MemToReg_in;
    logic        RegWrite_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic        Branch_in;
    logic [2:0]  trunk_mode_in;
    logic        stall_out;
    logic        pc_src_out;
    logic [10:0] branch_addr_out;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_reg_dest_out;
    logic        wb_RegWrite_out;
    logic        mem_err_out;

    int checks   = 0;
    int failures = 0;
    int stall_cycles;

    mem_access_stage_if #(.ADDR_W(10)) bus ();

    mem_access_stage #(.ADDR_W(10), .TIMEOUT(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .result_in         (result_in),
        .registro_2_in     (registro_2_in),
        .jump_dest_addr_in (jump_dest_addr_in),
        .zero_signal_in    (zero_signal_in),
        .reg_dest_in       (reg_dest_in),
        .MemToReg_in       (MemToReg_in),
        .RegWrite_in       (RegWrite_in),
        .MemRead_in        (MemRead_in),
        .MemWrite_in       (MemWrite_in),
        .Branch_in         (Branch_in),
        .trunk_mode_in     (trunk_mode_in),
        .mem_bus           (bus),
        .stall_out         (stall_out),
        .pc_src_out        (pc_src_out),
        .branch_addr_out   (branch_addr_out),
        .wb_data_out       (wb_data_out),
        .wb_reg_dest_out   (wb_reg_dest_out),
        .wb_RegWrite_out   (wb_RegWrite_out),
        .mem_err_out       (mem_err_out)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_ops();
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        MemToReg_in = 1'b0;
        Branch_in   = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        result_in = 32'h0; registro_2_in = 32'h0; jump_dest_addr_in = 11'h0;
        zero_signal_in = 1'b0; reg_dest_in = 5'd0; RegWrite_in = 1'b0;
        trunk_mode_in = 3'b000; bus.mem_rdata = 32'h0;
        clear_ops();
        #12;
        chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst_be",    {28'd0, bus.mem_be}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_RegWrite_out}, 32'd0);
        chk("rst_err",   {31'd0, mem_err_out}, 32'd0);
        reset_n = 1'b1;

        // ALU pass-through
        result_in = 32'h0000_1234; RegWrite_in = 1'b1; reg_dest_in = 5'd5;
        #1 chk("alu_stall_pre", {31'd0, stall_out}, 32'd0);
        tick();
        chk("alu_wb_data", wb_data_out, 32'h0000_1234);
        chk("alu_wb_dest", {27'd0, wb_reg_dest_out}, 32'd5);
        chk("alu_wb_we",   {31'd0, wb_RegWrite_out}, 32'd1);
        chk("alu_stall",   {31'd0, stall_out}, 32'd0);

        // Byte signed load, ack on the 4th WAIT cycle
        result_in = 32'h0000_0006; trunk_mode_in = 3'b100; MemRead_in = 1'b1;
        MemToReg_in = 1'b1; RegWrite_in = 1'b1; reg_dest_in = 5'd7;
        bus.mem_rdata = 32'h00AB_0000;
        #1;
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (stall_out === 1'b1) stall_cycles++;
            tick();
            if (i == 0) begin
                chk("lb_req",   {31'd0, bus.mem_req}, 32'd1);
                chk("lb_we",    {31'd0, bus.mem_we}, 32'd0);
                chk("lb_addr",  {22'd0, bus.mem_addr}, 32'd1);
                chk("lb_be",    {28'd0, bus.mem_be}, 32'hF);
                chk("lb_bubble",{31'd0, wb_RegWrite_out}, 32'd0);
            end
        end
        chk("lb_stall_cycles", stall_cycles, 32'd4);
        chk("lb_req_held", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1;
        #1 chk("lb_stall_ack", {31'd0, stall_out}, 32'd0);
        tick();
        chk("lb_wb_data", wb_data_out, 32'hFFFF_FFAB);
        chk("lb_wb_we",   {31'd0, wb_RegWrite_out}, 32'd1);
        chk("lb_wb_dest", {27'd0, wb_reg_dest_out}, 32'd7);
        chk("lb_req_off", {31'd0, bus.mem_req}, 32'd0);
        clear_ops();

        // Half store to upper half
        result_in = 32'h0000_000A; registro_2_in = 32'hDEAD_1234; trunk_mode_in = 3'b001;
        MemWrite_in = 1'b1; RegWrite_in = 1'b0;
        tick();
        chk("sh_req",   {31'd0, bus.mem_req}, 32'd1);
        chk("sh_we",    {31'd0, bus.mem_we}, 32'd1);
        chk("sh_be",    {28'd0, bus.mem_be}, 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'h1234_1234);
        chk("sh_addr",  {22'd0, bus.mem_addr}, 32'd2);
        bus.mem_ack = 1'b1;
        tick();
        chk("sh_req_off", {31'd0, bus.mem_req}, 32'd0);
        chk("sh_wb_we",   {31'd0, wb_RegWrite_out}, 32'd0);
        chk("sh_err",     {31'd0, mem_err_out}, 32'd0);
        clear_ops();

        // Timeout: 4 WAIT cycles without ack
        result_in = 32'h0000_0010; trunk_mode_in = 3'b000; MemRead_in = 1'b1;
        RegWrite_in = 1'b1; reg_dest_in = 5'd3;
        tick();
        chk("to_req", {31'd0, bus.mem_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("to_stall", {31'd0, stall_out}, 32'd1);
            tick();
        end
        chk("to_stall_last", {31'd0, stall_out}, 32'd0);
        chk("to_req_last",   {31'd0, bus.mem_req}, 32'd1);
        tick();
        chk("to_req_off", {31'd0, bus.mem_req}, 32'd0);
        chk("to_err",     {31'd0, mem_err_out}, 32'd1);
        chk("to_wb_we",   {31'd0, wb_RegWrite_out}, 32'd0);
        clear_ops();
        result_in = 32'h0000_0055; reg_dest_in = 5'd9; bus.mem_ack = 1'b1;
        #1 chk("late_ack_stall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("late_ack_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("late_ack_data", wb_data_out, 32'h0000_0055);
        chk("late_ack_err",  {31'd0, mem_err_out}, 32'd1);
        bus.mem_ack = 1'b0;

        // Error cleared only by reset
        reset_n = 1'b0;
        #1 chk("err_cleared", {31'd0, mem_err_out}, 32'd0);
        reset_n = 1'b1;

        // Misaligned word load
        result_in = 32'h0000_0002; trunk_mode_in = 3'b000; MemRead_in = 1'b1;
        MemToReg_in = 1'b1; RegWrite_in = 1'b1;
        #1 chk("mis_stall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("mis_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("mis_err",   {31'd0, mem_err_out}, 32'd1);
        chk("mis_wb_we", {31'd0, wb_RegWrite_out}, 32'd0);
        tick();
        chk("mis_req2",  {31'd0, bus.mem_req}, 32'd0);
        clear_ops();

        // Branch resolution, then reset mid-WAIT
        Branch_in = 1'b1; zero_signal_in = 1'b1; jump_dest_addr_in = 11'h155;
        #1;
        chk("br_pc_src", {31'd0, pc_src_out}, 32'd1);
        chk("br_addr",   {21'd0, branch_addr_out}, 32'h155);
        result_in = 32'h0000_0020; MemRead_in = 1'b1;
        #1;
        chk("br_stall",        {31'd0, stall_out}, 32'd1);
        chk("br_pc_src_stall", {31'd0, pc_src_out}, 32'd0);
        tick();
        chk("br_req", {31'd0, bus.mem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("arst_addr",  {22'd0, bus.mem_addr}, 32'd0);
        chk("arst_be",    {28'd0, bus.mem_be}, 32'd0);
        chk("arst_wdata", bus.mem_wdata, 32'd0);
        chk("arst_wdat",  wb_data_out, 32'd0);
        chk("arst_wdest", {27'd0, wb_reg_dest_out}, 32'd0);
        chk("arst_wwe",   {31'd0, wb_RegWrite_out}, 32'd0);
        chk("arst_err",   {31'd0, mem_err_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
